// File: rtl/bcd_display_scanner.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// bcd_display_scanner
//
// Drives a 3-digit common-anode 7-segment display. The hundreds, tens and
// units digits take turns on one shared active-low segment bus. Before each
// digit slot there is a short blanking gap with every anode off, so the
// segment pattern of one digit never shows faintly on its neighbour.
//
// The digit extractor upstream presents new digits together with a load
// strobe. Those digits are held in a pending set. The displayed (active) set
// is replaced only when the hundreds slot starts, so a frame never mixes old
// and new digits.
//
// Parameters
//   SCAN_DIV      cycles each digit slot is lit (>= 1)
//   BLANK_CYCLES  cycles all anodes are off before each slot (>= 1)
//   LZB           1 = blank leading zeros, 0 = always show three digits
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous reset, active low
//   digit_1      in   hundreds BCD digit
//   digit_2      in   tens BCD digit
//   digit_3      in   units BCD digit
//   load         in   capture digit_1..3 on this clock edge
//   seg          out  segments, active low, seg[0]=a .. seg[6]=g
//   an           out  anode enables, active low, an[2]=hundreds .. an[0]=units
//   frame_start  out  one-cycle pulse on the first lit cycle of the hundreds slot
//
// Timing: the outputs are registered from the next-state values, so they
// change on the same edge as the scan state they belong to. A full frame
// takes 3*(BLANK_CYCLES+SCAN_DIV) cycles.
// -----------------------------------------------------------------------------
module bcd_display_scanner #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 16,
    parameter int LZB          = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] digit_1,
    input  logic [3:0] digit_2,
    input  logic [3:0] digit_3,
    input  logic       load,
    output logic [6:0] seg,
    output logic [2:0] an,
    output logic       frame_start
);

    // One counter serves both states, so it is sized for the longer of the
    // two phases.
    localparam int CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [2:0] AN_OFF  = 3'b111;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        IDX_HUND  = 2'd0,
        IDX_TENS  = 2'd1,
        IDX_UNITS = 2'd2
    } idx_t;

    // Segment patterns in gfedcba order, active low. Codes 10..15 are not
    // BCD; they show a minus sign so a fault upstream is visible on the display.
    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    idx_t             idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [3:0] pend_1_q, pend_2_q, pend_3_q;
    logic [3:0] pend_1_d, pend_2_d, pend_3_d;
    logic [3:0] act_1_q, act_2_q, act_3_q;
    logic [3:0] act_1_d, act_2_d, act_3_d;

    logic [6:0] seg_q, seg_d;
    logic [2:0] an_q, an_d;
    logic       fs_q, fs_d;

    logic       commit;
    logic [3:0] sel_digit;
    logic       slot_blanked;

    // ------------------------------------------------------------------
    // Scan sequencing: BLANK gap, then SHOW, per digit slot
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q + CNT_W'(1);

        case (state_q)
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_SHOW;
                    cnt_d   = '0;
                end
            end
            ST_SHOW: begin
                if (cnt_q == SHOW_LAST) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    case (idx_q)
                        IDX_HUND: idx_d = IDX_TENS;
                        IDX_TENS: idx_d = IDX_UNITS;
                        default:  idx_d = IDX_HUND;
                    endcase
                end
            end
            default: begin
                state_d = ST_BLANK;
                idx_d   = IDX_HUND;
                cnt_d   = '0;
            end
        endcase
    end

    // The frame boundary: the edge that takes the hundreds slot from its
    // gap into its lit phase. idx does not move during BLANK, so idx_q
    // already names the slot being entered.
    assign commit = (state_q == ST_BLANK) && (state_d == ST_SHOW) && (idx_q == IDX_HUND);

    // ------------------------------------------------------------------
    // Pending / active digit sets
    // ------------------------------------------------------------------
    always_comb begin
        pend_1_d = pend_1_q;
        pend_2_d = pend_2_q;
        pend_3_d = pend_3_q;
        if (load) begin
            pend_1_d = digit_1;
            pend_2_d = digit_2;
            pend_3_d = digit_3;
        end

        // Taking the active set from pend_*_d rather than pend_*_q means a
        // load on the commit edge goes straight to the display.
        act_1_d = act_1_q;
        act_2_d = act_2_q;
        act_3_d = act_3_q;
        if (commit) begin
            act_1_d = pend_1_d;
            act_2_d = pend_2_d;
            act_3_d = pend_3_d;
        end
    end

    // ------------------------------------------------------------------
    // Output decode, computed from the next state so that the registered
    // outputs line up with the scan state they belong to.
    // ------------------------------------------------------------------
    always_comb begin
        case (idx_d)
            IDX_HUND: sel_digit = act_1_d;
            IDX_TENS: sel_digit = act_2_d;
            default:  sel_digit = act_3_d;
        endcase

        // Leading-zero blanking: the tens digit is only a leading zero
        // when the hundreds digit is zero too. The units digit always shows,
        // so a value of zero reads "0" and not an empty display.
        slot_blanked = 1'b0;
        if (LZB != 0) begin
            if (idx_d == IDX_HUND) begin
                slot_blanked = (act_1_d == 4'd0);
            end else if (idx_d == IDX_TENS) begin
                slot_blanked = (act_1_d == 4'd0) && (act_2_d == 4'd0);
            end
        end
    end

    always_comb begin
        seg_d = SEG_OFF;
        an_d  = AN_OFF;
        fs_d  = commit;

        if ((state_d == ST_SHOW) && !slot_blanked) begin
            seg_d = decode(sel_digit);
            case (idx_d)
                IDX_HUND: an_d = 3'b011;
                IDX_TENS: an_d = 3'b101;
                default:  an_d = 3'b110;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_BLANK;
            idx_q    <= IDX_HUND;
            cnt_q    <= '0;
            pend_1_q <= 4'd0;
            pend_2_q <= 4'd0;
            pend_3_q <= 4'd0;
            act_1_q  <= 4'd0;
            act_2_q  <= 4'd0;
            act_3_q  <= 4'd0;
            seg_q    <= SEG_OFF;
            an_q     <= AN_OFF;
            fs_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            pend_1_q <= pend_1_d;
            pend_2_q <= pend_2_d;
            pend_3_q <= pend_3_d;
            act_1_q  <= act_1_d;
            act_2_q  <= act_2_d;
            act_3_q  <= act_3_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
            fs_q     <= fs_d;
        end
    end

    assign seg         = seg_q;
    assign an          = an_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
`timescale 1ns/1ps
module tb_bcd_display_scanner;

    localparam int SD    = 4;
    localparam int BC    = 2;
    localparam int SLOT  = SD + BC;
    localparam int FRAME = 3 * SLOT;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] d1, d2, d3;
    logic       load;
    logic [6:0] seg_a, seg_b;
    logic [2:0] an_a, an_b;
    logic       fs_a, fs_b;

    always #5 clk = ~clk;

    bcd_display_scanner #(.SCAN_DIV(SD), .BLANK_CYCLES(BC), .LZB(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .digit_1(d1), .digit_2(d2), .digit_3(d3),
        .load(load), .seg(seg_a), .an(an_a), .frame_start(fs_a)
    );

    bcd_display_scanner #(.SCAN_DIV(SD), .BLANK_CYCLES(BC), .LZB(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .digit_1(d1), .digit_2(d2), .digit_3(d3),
        .load(load), .seg(seg_b), .an(an_b), .frame_start(fs_b)
    );

    // ---------------- scoreboard state ----------------
    int checks   = 0;
    int failures = 0;

    // Reference model: k = clock edges since reset release; digits committed
    // at the frame boundary (frame position BC).
    int         k;
    logic [3:0] pend [3];
    logic [3:0] act  [3];
    logic [6:0] seg_tab [16];

    typedef struct packed {
        logic [3:0] d1, d2, d3;
        logic [2:0] an_h, an_t, an_u;
        logic [6:0] seg_h, seg_t, seg_u;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [10:0] got, input logic [10:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got fs=%0b an=%03b seg=%07b, expected fs=%0b an=%03b seg=%07b",
                     name, got[10], got[9:7], got[6:0], exp[10], exp[9:7], exp[6:0]);
        end
    endtask

    function automatic logic [10:0] model_out(input int lzb);
        int         q, slot, r;
        logic       fs, blank;
        logic [2:0] an_v;
        q    = k % FRAME;
        slot = q / SLOT;
        r    = q % SLOT;
        fs   = (q == BC);
        if (r < BC) return {1'b0, 3'b111, 7'h7F};
        blank = (lzb != 0) && ((slot == 0 && act[0] == 4'd0) ||
                               (slot == 1 && act[0] == 4'd0 && act[1] == 4'd0));
        if (blank) return {fs, 3'b111, 7'h7F};
        an_v = 3'b111;
        an_v[2 - slot] = 1'b0;
        return {fs, an_v, seg_tab[act[slot]]};
    endfunction

    task automatic model_reset();
        k = 0;
        for (int i = 0; i < 3; i++) begin
            pend[i] = 4'd0;
            act[i]  = 4'd0;
        end
    endtask

    // ---------------- driver tasks ----------------
    // One clock edge: capture the driven inputs, advance the model, then
    // compare both instances 1 ns after the edge.
    task automatic tick(input string name);
        logic       ld;
        logic [3:0] a, b, c;
        ld = load; a = d1; b = d2; c = d3;
        @(posedge clk);
        if (rst_n) begin
            k++;
            if (ld) begin
                pend[0] = a; pend[1] = b; pend[2] = c;
            end
            if (k % FRAME == BC) begin
                for (int i = 0; i < 3; i++) act[i] = pend[i];
            end
        end
        #1;
        load = 1'b0;
        check({name, "_lzb1"}, {fs_a, an_a, seg_a}, model_out(1));
        check({name, "_lzb0"}, {fs_b, an_b, seg_b}, model_out(0));
    endtask

    task automatic set_load(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        d1 = a; d2 = b; d3 = c; load = 1'b1;
    endtask

    task automatic wait_fs(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            tick(name);
            if (fs_a) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s_fs_timeout: got no frame_start, expected one within 40 cycles", name);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected bench to finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main test ----------------
    initial begin
        int k0, n;

        seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001; seg_tab[2]  = 7'b0100100;
        seg_tab[3]  = 7'b0110000; seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
        seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000; seg_tab[8]  = 7'b0000000;
        seg_tab[9]  = 7'b0010000;
        for (int i = 10; i < 16; i++) seg_tab[i] = 7'b0111111;

        vecs[0] = '{4'd1, 4'd2, 4'd3, 3'b011, 3'b101, 3'b110, 7'b1111001, 7'b0100100, 7'b0110000};
        vecs[1] = '{4'd0, 4'd0, 4'd7, 3'b111, 3'b111, 3'b110, 7'h7F, 7'h7F, 7'b1111000};
        vecs[2] = '{4'd0, 4'd0, 4'd0, 3'b111, 3'b111, 3'b110, 7'h7F, 7'h7F, 7'b1000000};
        vecs[3] = '{4'hC, 4'd5, 4'd9, 3'b011, 3'b101, 3'b110, 7'b0111111, 7'b0010010, 7'b0010000};
        vecs[4] = '{4'd0, 4'd4, 4'd0, 3'b111, 3'b101, 3'b110, 7'h7F, 7'b0011001, 7'b1000000};
        vecs[5] = '{4'd8, 4'd0, 4'd6, 3'b011, 3'b101, 3'b110, 7'b0000000, 7'b1000000, 7'b0000010};

        // Reset: 5 cycles low, then release between edges.
        rst_n = 1'b0; load = 1'b0; d1 = 4'd0; d2 = 4'd0; d3 = 4'd0;
        model_reset();
        repeat (5) tick("reset");
        check("reset_const", {fs_a, an_a, seg_a}, {1'b0, 3'b111, 7'h7F});
        #3 rst_n = 1'b1;
        tick("post_reset");
        tick("post_reset");
        check("rst_lzb0_lit", {fs_b, an_b, seg_b}, {1'b1, 3'b011, 7'b1000000});
        check("rst_lzb1_dark", {fs_a, an_a, seg_a}, {1'b1, 3'b111, 7'h7F});

        // Table-driven vectors: one frame each, checked at the 2nd lit cycle of each slot.
        for (int v = 0; v < 6; v++) begin
            set_load(vecs[v].d1, vecs[v].d2, vecs[v].d3);
            wait_fs("vec_wait");
            k0 = k;
            while (k - k0 < 15) begin
                tick("vec_frame");
                if (k - k0 == 1)
                    check("vec_hund", {fs_a, an_a, seg_a}, {1'b0, vecs[v].an_h, vecs[v].seg_h});
                else if (k - k0 == SLOT + 1)
                    check("vec_tens", {fs_a, an_a, seg_a}, {1'b0, vecs[v].an_t, vecs[v].seg_t});
                else if (k - k0 == 2 * SLOT + 1)
                    check("vec_units", {fs_a, an_a, seg_a}, {1'b0, vecs[v].an_u, vecs[v].seg_u});
            end
        end

        // Frame period: frame_start spacing.
        wait_fs("period_a");
        n = 0;
        do begin
            tick("period");
            n++;
        end while (!fs_a && n < 40);
        checks++;
        if (n != FRAME) begin
            failures++;
            $display("FAIL frame_period: got %0d cycles, expected %0d", n, FRAME);
        end

        // Mid-frame load: 1,2,3 displayed, 4,5,6 loaded during tens slot.
        set_load(4'd1, 4'd2, 4'd3);
        wait_fs("mid_wait");
        k0 = k;
        while (k - k0 < 15) begin
            if (k - k0 == SLOT) set_load(4'd4, 4'd5, 4'd6);
            tick("mid_frame");
            if (k - k0 == SLOT + 1)
                check("mid_tens_old", {fs_a, an_a, seg_a}, {1'b0, 3'b101, 7'b0100100});
            else if (k - k0 == 2 * SLOT + 1)
                check("mid_units_old", {fs_a, an_a, seg_a}, {1'b0, 3'b110, 7'b0110000});
        end
        wait_fs("mid_next");
        tick("mid_next");
        check("mid_hund_new", {fs_a, an_a, seg_a}, {1'b0, 3'b011, 7'b0011001});

        // Load on the commit edge itself.
        n = 0;
        while ((k % FRAME) != BC - 1 && n < 40) begin
            tick("to_commit");
            n++;
        end
        set_load(4'd7, 4'd8, 4'd9);
        tick("commit_edge");
        check("commit_bypass", {fs_a, an_a, seg_a}, {1'b1, 3'b011, 7'b1111000});

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                set_load(($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15)),
                         ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15)),
                         4'($urandom_range(0, 15)));
            end
            tick("random");
        end

        // Async reset mid-SHOW with a pending load that must be discarded.
        set_load(4'd1, 4'd2, 4'd3);
        wait_fs("arst_wait");
        set_load(4'd4, 4'd4, 4'd4);
        tick("arst_pre");
        #2 rst_n = 1'b0;
        #1;
        check("arst_now_lzb1", {fs_a, an_a, seg_a}, {1'b0, 3'b111, 7'h7F});
        check("arst_now_lzb0", {fs_b, an_b, seg_b}, {1'b0, 3'b111, 7'h7F});
        model_reset();
        repeat (3) tick("arst_hold");
        #3 rst_n = 1'b1;
        for (int i = 0; i < FRAME; i++) begin
            tick("arst_after");
            if (k == BC + 1)
                check("arst_hund_zero", {fs_b, an_b, seg_b}, {1'b0, 3'b011, 7'b1000000});
            if (k == 2 * SLOT + BC + 1)
                check("arst_units_zero", {fs_a, an_a, seg_a}, {1'b0, 3'b110, 7'b1000000});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
